// File: rtl/snake_game_ctrl_if.sv
// Control/datapath bundle for the snake game controller.
// Handshake: step is a one-cycle, fire-and-forget pulse with no ready; the
// datapath must shift in next_yx (and lengthen by one when grow) on that edge.
interface snake_game_ctrl_if #(
  parameter int TICK_W = 8
);
  logic              start;
  logic              up;
  logic              down;
  logic              left;
  logic              right;
  logic [TICK_W-1:0] tick_period;
  logic [7:0]        head_yx;
  logic              hit_self;
  logic [7:0]        next_yx;
  logic              step;
  logic              grow;
  logic [1:0]        dir;
  logic [7:0]        food_yx;
  logic [7:0]        score;
  logic              alive;
  logic [2:0]        state;

  modport master (
    output start, up, down, left, right, tick_period, head_yx, hit_self,
    input  next_yx, step, grow, dir, food_yx, score, alive, state
  );

  modport slave (
    input  start, up, down, left, right, tick_period, head_yx, hit_self,
    output next_yx, step, grow, dir, food_yx, score, alive, state
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game controller: step timing, direction filtering, collision/eat
// decision, score keeping and LFSR-based food placement.
module snake_game_ctrl #(
  parameter int TICK_W = 8
) (
  input logic             slw_clk,
  input logic             reset,
  snake_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    CHECK = 3'd2,
    MOVE  = 3'd3,
    EAT   = 3'd4,
    DIE   = 3'd5
  } state_t;

  localparam logic [1:0] D_UP    = 2'b00;
  localparam logic [1:0] D_DOWN  = 2'b01;
  localparam logic [1:0] D_LEFT  = 2'b10;
  localparam logic [1:0] D_RIGHT = 2'b11;

  state_t            st;
  logic [TICK_W-1:0] tick_cnt;
  logic [1:0]        dir_q;
  logic [1:0]        pend_q;
  logic [7:0]        food_q;
  logic [7:0]        score_q;
  logic [7:0]        lfsr_q;
  logic              step_q;
  logic              grow_q;

  logic [7:0]        nxt;
  logic [1:0]        btn_dir;
  logic              lfsr_fb;
  logic [7:0]        new_food;

  // Each nibble wraps modulo 16 on its own.
  always_comb begin
    nxt = bus.head_yx;
    unique case (dir_q)
      D_UP:    nxt[7:4] = bus.head_yx[7:4] - 4'd1;
      D_DOWN:  nxt[7:4] = bus.head_yx[7:4] + 4'd1;
      D_LEFT:  nxt[3:0] = bus.head_yx[3:0] - 4'd1;
      D_RIGHT: nxt[3:0] = bus.head_yx[3:0] + 4'd1;
    endcase
  end

  // Priority up > down > left > right; a reversal falls through to the next button.
  always_comb begin
    btn_dir = pend_q;
    if (bus.up && dir_q != D_DOWN)         btn_dir = D_UP;
    else if (bus.down && dir_q != D_UP)    btn_dir = D_DOWN;
    else if (bus.left && dir_q != D_RIGHT) btn_dir = D_LEFT;
    else if (bus.right && dir_q != D_LEFT) btn_dir = D_RIGHT;
  end

  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign new_food = (lfsr_q == nxt) ? (lfsr_q + 8'h11) : lfsr_q;

  always_ff @(posedge slw_clk or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      tick_cnt <= '0;
      dir_q    <= D_RIGHT;
      pend_q   <= D_RIGHT;
      food_q   <= 8'h33;
      score_q  <= 8'h00;
      lfsr_q   <= 8'h01;
      step_q   <= 1'b0;
      grow_q   <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
      step_q <= 1'b0;
      grow_q <= 1'b0;
      case (st)
        IDLE: begin
          if (bus.start) begin
            dir_q    <= D_RIGHT;
            pend_q   <= D_RIGHT;
            food_q   <= 8'h33;
            score_q  <= 8'h00;
            tick_cnt <= '0;
            st       <= RUN;
          end
        end
        RUN: begin
          pend_q <= btn_dir;
          if (tick_cnt == bus.tick_period) begin
            tick_cnt <= '0;
            dir_q    <= pend_q;
            st       <= CHECK;
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        // step/grow are set here so they are high exactly during MOVE/EAT.
        CHECK: begin
          if (bus.hit_self) begin
            st <= DIE;
          end else if (nxt == food_q) begin
            step_q <= 1'b1;
            grow_q <= 1'b1;
            st     <= EAT;
          end else begin
            step_q <= 1'b1;
            st     <= MOVE;
          end
        end
        MOVE: st <= RUN;
        EAT: begin
          score_q <= (score_q == 8'hFF) ? 8'hFF : (score_q + 8'd1);
          food_q  <= new_food;
          st      <= RUN;
        end
        DIE: begin
          if (bus.start) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.next_yx = nxt;
  assign bus.step    = step_q;
  assign bus.grow    = grow_q;
  assign bus.dir     = dir_q;
  assign bus.food_yx = food_q;
  assign bus.score   = score_q;
  assign bus.alive   = (st == RUN) || (st == CHECK) || (st == MOVE) || (st == EAT);
  assign bus.state   = st;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed game scenarios with a
// step-event scoreboard and an independent LFSR/food/score model.
module tb_snake_game_ctrl;

  localparam int TICK_W = 8;

  logic slw_clk;
  logic reset;

  snake_game_ctrl_if #(.TICK_W(TICK_W)) bus ();

  snake_game_ctrl #(.TICK_W(TICK_W)) dut (
    .slw_clk (slw_clk),
    .reset   (reset),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    slw_clk = 1'b0;
    forever #5 slw_clk = ~slw_clk;
  end

  // ---------------- reference state ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];
  logic [7:0] m_lfsr;
  logic [7:0] m_food;
  logic [7:0] m_score;
  logic       prev_step;

  always @(posedge slw_clk or negedge reset) begin
    if (!reset) m_lfsr <= 8'h01;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [8:0] sb_e;
  always @(negedge slw_clk) begin
    if (!reset) begin
      prev_step = 1'b0;
    end else begin
      if (bus.step) begin
        check_val("step_back2back", prev_step, 1'b0);
        if (exp_q.size() == 0) begin
          check_val("sb_unexpected_step", {bus.grow, bus.next_yx}, 9'h000);
        end else begin
          sb_e = exp_q.pop_front();
          check_val("step_evt", {bus.grow, bus.next_yx}, sb_e);
        end
      end
      if (bus.grow) check_val("grow_alone", bus.step, 1'b1);
      prev_step = bus.step;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge slw_clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget);
    int n = 0;
    while (bus.state !== tgt && n < budget) begin
      tick();
      n++;
    end
    check_val("reach_state", bus.state, tgt);
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    bus.up = u; bus.down = d; bus.left = l; bus.right = r;
    tick();
    bus.up = 1'b0; bus.down = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
  endtask

  // One full RUN -> CHECK -> MOVE/EAT -> RUN round with the given head.
  task automatic do_step(input logic [7:0] h, input logic [1:0] edir,
                         input logic [7:0] enext, input logic eat);
    bus.head_yx = h;
    exp_q.push_back({eat, enext});
    wait_state(3'd2, 40);
    check_val("chk_dir", bus.dir, edir);
    check_val("chk_next", bus.next_yx, enext);
    tick();
    check_val("act_state", bus.state, eat ? 3'd4 : 3'd3);
    if (eat) begin
      m_food  = (m_lfsr == enext) ? (m_lfsr + 8'h11) : m_lfsr;
      m_score = (m_score == 8'hFF) ? 8'hFF : (m_score + 8'd1);
    end
    tick();
    check_val("run_state", bus.state, 3'd1);
    check_val("score", bus.score, m_score);
    check_val("food", bus.food_yx, m_food);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_state"}, bus.state, 3'd0);
    check_val({tag, "_dir"}, bus.dir, 2'b11);
    check_val({tag, "_step"}, bus.step, 1'b0);
    check_val({tag, "_grow"}, bus.grow, 1'b0);
    check_val({tag, "_alive"}, bus.alive, 1'b0);
    check_val({tag, "_score"}, bus.score, 8'h00);
    check_val({tag, "_food"}, bus.food_yx, 8'h33);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         run_cnt;
    logic [3:0] hx;
    reset = 1'b0;
    bus.start = 1'b0; bus.up = 1'b0; bus.down = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
    bus.tick_period = 8'd3;
    bus.head_yx = 8'h13;
    bus.hit_self = 1'b0;
    m_food = 8'h33;
    m_score = 8'h00;
    repeat (2) tick();
    check_reset_vals("rst");
    reset = 1'b1;
    repeat (3) tick();
    check_val("idle_hold", bus.state, 3'd0);

    // Start and basic step timing.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("start_state", bus.state, 3'd1);
    check_val("start_alive", bus.alive, 1'b1);
    check_val("start_dir", bus.dir, 2'b11);
    run_cnt = 1;
    while (bus.state == 3'd1 && run_cnt < 20) begin
      tick();
      if (bus.state == 3'd1) run_cnt++;
    end
    check_val("run_cycles", run_cnt, 4);
    exp_q.push_back({1'b0, 8'h14});
    check_val("first_check", bus.state, 3'd2);
    check_val("first_next", bus.next_yx, 8'h14);
    tick();
    check_val("first_move", bus.state, 3'd3);
    check_val("move_alive", bus.alive, 1'b1);
    tick();
    check_val("back_run", bus.state, 3'd1);
    check_val("step_after_move", bus.step, 1'b0);

    // Direction filtering and wrap-around.
    press(1'b0, 1'b0, 1'b1, 1'b0); do_step(8'h13, 2'b11, 8'h14, 1'b0);
    press(1'b1, 1'b0, 1'b1, 1'b0); do_step(8'h13, 2'b00, 8'h03, 1'b0);
    do_step(8'h05, 2'b00, 8'hF5, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b1); do_step(8'h0F, 2'b11, 8'h00, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0); do_step(8'hF7, 2'b01, 8'h07, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0); do_step(8'h70, 2'b10, 8'h7F, 1'b0);
    press(1'b1, 1'b1, 1'b0, 1'b0); do_step(8'h44, 2'b00, 8'h34, 1'b0);

    // First food: down is a reversal of up and is skipped in favour of right.
    press(1'b0, 1'b1, 1'b0, 1'b1); do_step(8'h32, 2'b11, 8'h33, 1'b1);

    // Eat repeatedly past score saturation.
    bus.tick_period = 8'd0;
    for (int i = 0; i < 256; i++) begin
      hx = m_food[3:0] - 4'd1;
      do_step({m_food[7:4], hx}, 2'b11, m_food, 1'b1);
    end
    check_val("score_sat", bus.score, 8'hFF);

    // Collision beats food.
    bus.tick_period = 8'd3;
    hx = m_food[3:0] - 4'd1;
    bus.head_yx = {m_food[7:4], hx};
    bus.hit_self = 1'b1;
    wait_state(3'd2, 40);
    check_val("die_next_is_food", bus.next_yx, m_food);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_val("die_state", bus.state, 3'd5);
      check_val("die_alive", bus.alive, 1'b0);
      check_val("die_step", bus.step, 1'b0);
      check_val("die_score", bus.score, m_score);
      check_val("die_food", bus.food_yx, m_food);
      press(1'b1, 1'b0, 1'b0, 1'b0);
    end
    bus.hit_self = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("die_to_idle", bus.state, 3'd0);

    // Reset in the middle of an EAT cycle.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_food = 8'h33;
    m_score = 8'h00;
    check_val("restart_score", bus.score, 8'h00);
    check_val("restart_food", bus.food_yx, 8'h33);
    bus.head_yx = 8'h32;
    exp_q.push_back({1'b1, 8'h33});
    wait_state(3'd4, 40);
    @(negedge slw_clk);
    #1 reset = 1'b0;
    #1;
    check_reset_vals("rst_eat");
    @(posedge slw_clk);
    #1 reset = 1'b1;
    repeat (3) tick();
    check_val("post_rst_idle", bus.state, 3'd0);
    check_val("post_rst_score", bus.score, 8'h00);

    check_val("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
